// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants, reset PC and fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'd4;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000033;
  typedef enum logic {BOOT, RUN} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC owner; imem_addr/imem_word to sync-read memory, stall/redirect in, if_instr/if_pc/if_valid/fetch_count to IF/ID
module fetch_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_word,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] fetch_count
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d, req_pc_q, req_pc_d, cnt_q, cnt_d, tgt;
  always_comb begin
    tgt = {redirect_pc[XLEN-1:2], 2'b00};
    imem_addr = redirect ? tgt : stall ? req_pc_q : fpc_q;
    if_valid = (state_q == RUN) & ~redirect;
    fpc_d = redirect ? tgt + XLEN'(INSTR_BYTES) : stall ? fpc_q : fpc_q + XLEN'(INSTR_BYTES);
    req_pc_d = redirect ? tgt : stall ? req_pc_q : fpc_q;
    state_d = (redirect | ~stall) ? RUN : state_q;
    cnt_d = cnt_q + XLEN'(if_valid & ~stall);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      state_q <= BOOT;
      cnt_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      req_pc_q <= req_pc_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign if_pc = req_pc_q;
  assign if_instr = imem_word;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit against a sync-read memory model
module tb_fetch_unit;
  logic clk = 0, rst = 1, stall = 0, redirect = 0, if_valid;
  logic [31:0] imem_addr, imem_word = '0, redirect_pc = '0, if_instr, if_pc, fetch_count;
  int checks = 0, failures = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_word(imem_word),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a == 32'd4  ? 32'h00910193 :
           a == 32'd8  ? 32'h00000033 :
           a == 32'd12 ? 32'h00000033 :
           a == 32'd16 ? 32'h00518213 : {16'hBEEF, a[15:0]};
  endfunction
  always @(posedge clk) imem_word <= mem_rd(imem_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = r;
    stall = s;
    redirect = rd;
    redirect_pc = t;
    #1;
  endtask
  task automatic see(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_cnt"}, fetch_count, cnt);
    if (v) chk({tag, "_instr"}, if_instr, mem_rd(pc));
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_addr", imem_addr, 32'd4);
    see("rst", 0, 32'd4, 0);
    cyc(0, 0, 0, 0);
    see("boot", 0, 32'd4, 0);
    cyc(0, 0, 0, 0);
    chk("run4_word", if_instr, 32'h00910193);
    see("run4", 1, 32'd4, 0);
    cyc(0, 0, 0, 0);
    see("run8", 1, 32'd8, 1);
    cyc(0, 0, 0, 0);
    see("run12", 1, 32'd12, 2);
    cyc(0, 0, 0, 0);
    chk("run16_word", if_instr, 32'h00518213);
    see("run16", 1, 32'd16, 3);
    cyc(0, 0, 1, 32'd8);
    see("rd8", 0, 32'd20, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("stall_addr", imem_addr, 32'd8);
      see("stall8", 1, 32'd8, 4);
    end
    cyc(0, 0, 0, 0);
    see("unstall8", 1, 32'd8, 4);
    cyc(0, 0, 1, 32'h1E);
    chk("rd1e_addr", imem_addr, 32'h1C);
    see("rd1e", 0, 32'd12, 5);
    cyc(0, 0, 0, 0);
    see("tgt1c", 1, 32'h1C, 5);
    cyc(0, 0, 0, 0);
    see("tgt20", 1, 32'h20, 6);
    cyc(0, 0, 1, 32'd4);
    see("rd4", 0, 32'h24, 7);
    cyc(0, 1, 1, 32'd16);
    chk("rdst_addr", imem_addr, 32'd16);
    see("rdst", 0, 32'd4, 7);
    cyc(0, 0, 1, 32'hFFFFFFFC);
    see("rdst16", 0, 32'd16, 7);
    chk("rdst16_word", if_instr, 32'h00518213);
    cyc(0, 0, 0, 0);
    see("wrapfc", 1, 32'hFFFFFFFC, 7);
    cyc(0, 0, 0, 0);
    see("wrap0", 1, 32'd0, 8);
    cyc(0, 0, 0, 0);
    see("wrap4", 1, 32'd4, 9);
    cyc(0, 0, 0, 0);
    see("wrap8", 1, 32'd8, 10);
    cyc(0, 0, 0, 0);
    see("wrap12", 1, 32'd12, 11);
    cyc(0, 1, 1, 32'd40);
    cyc(1, 1, 1, 32'd40);
    cyc(0, 1, 0, 0);
    see("mrst", 0, 32'd4, 0);
    cyc(0, 0, 0, 0);
    see("bootstall", 0, 32'd4, 0);
    cyc(0, 0, 0, 0);
    see("restart4", 1, 32'd4, 0);
    cyc(0, 0, 0, 0);
    see("restart8", 1, 32'd8, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator for the RV32I core: owns the fetch PC, drives word addresses into the synchronous-read instruction memory and pairs each returned word with its PC for the IF/ID stage. The block handles the memory's one-cycle read latency, decode-stage stalls and branch/jump redirects. It sits between the instruction memory and the decode stage.

## Interface
- RESET_PC, 32'd4: first fetch address after reset.
- clk  in  1  rising-edge clock shared with the instruction memory.
- rst  in  1  reset; synchronous, active-high.
- imem_addr  out  32  byte address presented to the instruction memory; sampled by the memory on each rising clk edge.
- imem_word  in  32  memory read data, valid one cycle after the address edge.
- stall  in  1  decode stage cannot accept; hold the current IF/ID contents.
- redirect  in  1  taken branch or jump; restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0.
- if_instr  out  32  fetched instruction, equal to imem_word.
- if_pc  out  32  PC of if_instr.
- if_valid  out  1  if_instr/if_pc hold a correct-path instruction.
- fetch_count  out  32  number of instructions delivered, i.e. cycles with if_valid=1 and stall=0.

## Operation
- Registers:
  - fpc: next address to issue.
  - req_pc: address whose word is currently on imem_word.
  - state: BOOT or RUN.
  - fetch_count.
- imem_addr is chosen combinationally, in priority order:
  - redirect=1: {redirect_pc[31:2],2'b00}
  - stall=1: req_pc. The same word is re-read, so imem_word stays stable.
  - otherwise: fpc.
- Each edge, in priority order:
  - rst: fpc<=RESET_PC, req_pc<=RESET_PC, state<=BOOT, fetch_count<=0.
  - redirect: req_pc<=aligned target, fpc<=target+4, state<=RUN.
  - stall: all registers hold.
  - otherwise: req_pc<=fpc, fpc<=fpc+4, state<=RUN.
- if_valid = (state==RUN) & ~redirect. The wrong-path word present during the redirect cycle is squashed.
- if_pc = req_pc; if_instr = imem_word.
- fetch_count increments when if_valid & ~stall. It wraps modulo 2^32.
- fpc+4 wraps modulo 2^32, so 32'hFFFFFFFC is followed by 0. No trap is raised.
- Redirect and stall asserted together: redirect wins, and the stall is ignored for that cycle.
- Stall in BOOT: hold BOOT. The first fetch issues when stall drops.

## Timing
- Reset values:
  - imem_addr = RESET_PC (with redirect=0, stall=0)
  - if_pc = RESET_PC
  - if_valid = 0
  - fetch_count = 0
  - if_instr follows memory data and is don't-care while if_valid=0.
- Fetch latency: an address issued at edge k produces if_valid=1 with its word after edge k. The first valid instruction appears one cycle after rst deasserts.
- Sustained throughput: one instruction per cycle with no bubbles.
- Redirect penalty: the redirect cycle's IF/ID output is squashed, and the target instruction is valid the next cycle. That is one bubble.
- Stall: if_instr, if_pc and if_valid stay unchanged for every stalled cycle. Fetch resumes at the following address on the first unstalled edge.
- rst mid-stream overrides stall and redirect. if_valid=0 on the cycle after the rst edge.

## Structure
- Put these in the shared package riscv_pkg:
  - XLEN = 32
  - INSTR_BYTES = 4
  - default RESET_PC
  - INSTR_NOP = 32'h00000033
  - enum fetch_state_t {BOOT, RUN}
- No sub-module. The PC adder and the address mux stay inline.
- Expected RTL size is roughly 120-160 lines.

## Test plan
- Reset, then free-run against a memory holding 4:00910193, 8:00000033, 12:00000033, 16:00518213 → if_valid=0 for the first cycle; then pairs (4,00910193), (8,00000033), (12,00000033), (16,00518213) on consecutive cycles; fetch_count=4.
- Stall for 3 cycles while if_pc=8 → if_pc=8, if_instr=00000033 and if_valid=1 throughout; the next cycle shows pc 12; fetch_count does not advance while stalled.
- Redirect to 32'h0000001E while if_pc=12 → if_valid=0 that cycle; the next cycle shows if_pc=0x1C; then 0x20.
- Redirect and stall together at if_pc=4, target 16 → the redirect wins; the next cycle shows (16,00518213).
- Redirect to 32'hFFFFFFFC → if_pc=FFFFFFFC, then 0, then 4 (00910193); no stall or error.
- Assert rst for one cycle mid-stream at if_pc=16 → if_valid=0 and fetch_count=0 on the next cycle; fetch restarts at 4.
